// File: rtl/serial_top_k_pkg.sv
// Shared types and constants for the streaming top-K ranker.
package serial_top_k_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  localparam int MODE_MAX = 0;
  localparam int MODE_MIN = 1;

endpackage

// File: rtl/serial_top_k_cmp.sv
// Strict "a is better than b" compare for one ranking slot.
module top_k_cmp #(
  parameter int WIDTH      = 8,
  parameter int MODE_MIN   = 0,
  parameter int SIGNED_CMP = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             better
);

  logic gt;
  logic lt;

  // Ordering picks greater or less; signedness picks the interpretation.
  always_comb begin
    if (SIGNED_CMP != 0) begin
      gt = ($signed(a) > $signed(b));
      lt = ($signed(a) < $signed(b));
    end else begin
      gt = (a > b);
      lt = (a < b);
    end
    better = (MODE_MIN == serial_top_k_pkg::MODE_MAX) ? gt : lt;
  end

endmodule

// File: rtl/serial_top_k.sv
// Streaming top-K ranker: collects a frame into a sorted table, then
// emits the ranked entries best-first.
//
//   state   | meaning
//   COLLECT | accept samples, insert each into the sorted table
//   EMIT    | present slot[ptr] downstream, advance on handshake
module serial_top_k #(
  parameter int WIDTH      = 8,
  parameter int K          = 4,
  parameter int IDX_W      = 8,
  parameter int MODE_MIN   = 0,
  parameter int SIGNED_CMP = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [IDX_W-1:0]                 out_index,
  output logic [((K > 1) ? $clog2(K) : 1)-1:0] out_rank,
  output logic                             out_last
);
  import serial_top_k_pkg::*;

  localparam int RANK_W = (K > 1) ? $clog2(K) : 1;

  state_t             state;
  logic [RANK_W-1:0]  ptr;
  logic [IDX_W-1:0]   idx;
  logic [K-1:0]       slot_valid;
  logic [WIDTH-1:0]   slot_data  [K];
  logic [IDX_W-1:0]   slot_index [K];

  logic [K-1:0]       nxt_valid;
  logic [WIDTH-1:0]   nxt_data   [K];
  logic [IDX_W-1:0]   nxt_index  [K];
  logic [K-1:0]       take;
  logic [K-1:0]       found;

  logic [WIDTH-1:0]   sel_data;
  logic [IDX_W-1:0]   sel_index;
  logic               last_c;
  logic [K:0]         vext;

  assign found[0] = 1'b0;
  assign vext     = {1'b0, slot_valid};

  // Shift-insert network: found[r] means the new sample lands above rank r,
  // so slot r inherits slot r-1; the first slot that takes gets the sample.
  for (genvar r = 0; r < K; r++) begin : g_slot
    logic beat;

    top_k_cmp #(
      .WIDTH      (WIDTH),
      .MODE_MIN   (MODE_MIN),
      .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp (
      .a      (in_data),
      .b      (slot_data[r]),
      .better (beat)
    );

    assign take[r] = !slot_valid[r] || beat;

    if (r < K - 1) begin : g_chain
      assign found[r+1] = found[r] | take[r];
    end

    if (r == 0) begin : g_head
      assign nxt_valid[r] = take[r] ? 1'b1    : slot_valid[r];
      assign nxt_data[r]  = take[r] ? in_data : slot_data[r];
      assign nxt_index[r] = take[r] ? idx     : slot_index[r];
    end else begin : g_body
      assign nxt_valid[r] = found[r] ? slot_valid[r-1] :
                            (take[r] ? 1'b1 : slot_valid[r]);
      assign nxt_data[r]  = found[r] ? slot_data[r-1] :
                            (take[r] ? in_data : slot_data[r]);
      assign nxt_index[r] = found[r] ? slot_index[r-1] :
                            (take[r] ? idx : slot_index[r]);
    end
  end

  // Select the entry under the emit pointer and whether it is the last one.
  always_comb begin
    sel_data  = '0;
    sel_index = '0;
    last_c    = 1'b0;
    for (int r = 0; r < K; r++) begin
      if (ptr == RANK_W'(r)) begin
        sel_data  = slot_data[r];
        sel_index = slot_index[r];
        last_c    = !vext[r+1];
      end
    end
  end

  assign out_data  = out_valid ? sel_data  : '0;
  assign out_index = out_valid ? sel_index : '0;
  assign out_rank  = out_valid ? ptr       : '0;
  assign out_last  = out_valid & last_c;

  // Control FSM, table update and handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      ptr        <= '0;
      idx        <= '0;
      slot_valid <= '0;
      for (int r = 0; r < K; r++) begin
        slot_data[r]  <= '0;
        slot_index[r] <= '0;
      end
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid && in_ready) begin
            slot_valid <= nxt_valid;
            slot_data  <= nxt_data;
            slot_index <= nxt_index;
            idx        <= idx + 1'b1;
            if (in_last) begin
              state     <= EMIT;
              ptr       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            if (last_c) begin
              state      <= COLLECT;
              slot_valid <= '0;
              idx        <= '0;
              ptr        <= '0;
              in_ready   <= 1'b1;
              out_valid  <= 1'b0;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_top_k.sv
// Directed bench: three ranker instances (default, unsigned-min, 2-bit index).
module tb_serial_top_k;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       va = 1'b0, vb = 1'b0, vc = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic       ra, rb, rc;
  logic       ova, ovb, ovc;
  logic [7:0] da, db, dc;
  logic [7:0] ia, ib;
  logic [1:0] ic;
  logic [1:0] ka, kb, kc;
  logic       la, lb, lc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_top_k u_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(ra), .in_data(in_data),
    .in_last(in_last), .out_valid(ova), .out_ready(out_ready), .out_data(da),
    .out_index(ia), .out_rank(ka), .out_last(la)
  );

  serial_top_k #(.MODE_MIN(1), .SIGNED_CMP(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .in_data(in_data),
    .in_last(in_last), .out_valid(ovb), .out_ready(out_ready), .out_data(db),
    .out_index(ib), .out_rank(kb), .out_last(lb)
  );

  serial_top_k #(.IDX_W(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(vc), .in_ready(rc), .in_data(in_data),
    .in_last(in_last), .out_valid(ovc), .out_ready(out_ready), .out_data(dc),
    .out_index(ic), .out_rank(kc), .out_last(lc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [7:0] d, input logic l);
    in_data = d;
    in_last = l;
    case (sel)
      0: va = 1'b1;
      1: vb = 1'b1;
      default: vc = 1'b1;
    endcase
    tick();
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic expect_entry(input int sel, input string tag, input logic [7:0] d,
                              input logic [7:0] i, input logic [7:0] r, input logic l);
    logic       ov, ol, rdy;
    logic [7:0] od, oi, orr;
    case (sel)
      0: begin ov = ova; od = da; oi = ia; orr = {6'd0, ka}; ol = la; rdy = ra; end
      1: begin ov = ovb; od = db; oi = ib; orr = {6'd0, kb}; ol = lb; rdy = rb; end
      default: begin ov = ovc; od = dc; oi = {6'd0, ic}; orr = {6'd0, kc}; ol = lc; rdy = rc; end
    endcase
    chk({tag, "_valid"}, 32'(ov), 32'd1);
    chk({tag, "_ready"}, 32'(rdy), 32'd0);
    chk({tag, "_data"},  32'(od), 32'(d));
    chk({tag, "_index"}, 32'(oi), 32'(i));
    chk({tag, "_rank"},  32'(orr), 32'(r));
    chk({tag, "_last"},  32'(ol), 32'(l));
    if (out_ready) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready",  32'(ra), 32'd1);
    chk("rst_out_valid", 32'(ova), 32'd0);
    chk("rst_out_data",  32'(da), 32'd0);
    chk("rst_out_index", 32'(ia), 32'd0);
    chk("rst_out_rank",  32'(ka), 32'd0);
    chk("rst_out_last",  32'(la), 32'd0);

    // Default mode: 5,-3,9,9,1,7 (last on 7)
    send(0, 8'd5, 1'b0);
    send(0, 8'hFD, 1'b0);
    send(0, 8'd9, 1'b0);
    send(0, 8'd9, 1'b0);
    send(0, 8'd1, 1'b0);
    send(0, 8'd7, 1'b1);
    expect_entry(0, "a0", 8'd9, 8'd2, 8'd0, 1'b0);
    expect_entry(0, "a1", 8'd9, 8'd3, 8'd1, 1'b0);
    expect_entry(0, "a2", 8'd7, 8'd5, 8'd2, 1'b0);
    expect_entry(0, "a3", 8'd5, 8'd0, 8'd3, 1'b1);
    chk("a_back_ready", 32'(ra), 32'd1);
    chk("a_back_valid", 32'(ova), 32'd0);

    // Stall during EMIT with in_valid pulses that must be ignored
    send(0, 8'd3, 1'b0);
    send(0, 8'd8, 1'b1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_data = 8'd100;
      va = (c % 2 == 0);
      expect_entry(0, "stall", 8'd8, 8'd1, 8'd0, 1'b0);
      tick();
    end
    va = 1'b0;
    out_ready = 1'b1;
    expect_entry(0, "s0", 8'd8, 8'd1, 8'd0, 1'b0);
    expect_entry(0, "s1", 8'd3, 8'd0, 8'd1, 1'b1);

    // Single sample -128 frame; index restarts at 0
    send(0, 8'h80, 1'b1);
    expect_entry(0, "single", 8'h80, 8'd0, 8'd0, 1'b1);
    chk("single_ready_after", 32'(ra), 32'd1);
    chk("single_valid_after", 32'(ova), 32'd0);

    // Unsigned min mode: 200,10,255 (last on 255)
    send(1, 8'd200, 1'b0);
    send(1, 8'd10, 1'b0);
    send(1, 8'd255, 1'b1);
    expect_entry(1, "b0", 8'd10,  8'd1, 8'd0, 1'b0);
    expect_entry(1, "b1", 8'd200, 8'd0, 8'd1, 1'b0);
    expect_entry(1, "b2", 8'd255, 8'd2, 8'd2, 1'b1);
    chk("b_back_ready", 32'(rb), 32'd1);

    // Reset mid-frame, then a one-sample frame
    send(0, 8'd1, 1'b0);
    send(0, 8'd2, 1'b0);
    send(0, 8'd3, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", 32'(ra), 32'd1);
    chk("midrst_valid", 32'(ova), 32'd0);
    send(0, 8'd4, 1'b1);
    expect_entry(0, "midrst", 8'd4, 8'd0, 8'd0, 1'b1);

    // Reset mid-emit with a pending handshake: reset wins
    send(0, 8'd6, 1'b0);
    send(0, 8'd7, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("emitrst_valid", 32'(ova), 32'd0);
    chk("emitrst_ready", 32'(ra), 32'd1);
    chk("emitrst_data",  32'(da), 32'd0);
    send(0, 8'd2, 1'b1);
    expect_entry(0, "emitrst_next", 8'd2, 8'd0, 8'd0, 1'b1);

    // 2-bit index wraps: max at position 5 reports index 1
    send(2, 8'd1, 1'b0);
    send(2, 8'd2, 1'b0);
    send(2, 8'd3, 1'b0);
    send(2, 8'd4, 1'b0);
    send(2, 8'd5, 1'b0);
    send(2, 8'd50, 1'b1);
    expect_entry(2, "c0", 8'd50, 8'd1, 8'd0, 1'b0);
    expect_entry(2, "c1", 8'd5,  8'd0, 8'd1, 1'b0);
    expect_entry(2, "c2", 8'd4,  8'd3, 8'd2, 1'b0);
    expect_entry(2, "c3", 8'd3,  8'd2, 8'd3, 1'b1);
    chk("c_back_ready", 32'(rc), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
